// File: rtl/audio_sample_interp_if.sv
// Sample stream into the interpolator: signed 16-bit PCM with a valid/ready handshake.
interface audio_sample_interp_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/audio_sample_interp.sv
// Buffers PCM samples in a small FIFO and plays them out every 2^PHASE_BITS clocks,
// linearly interpolating between consecutive samples into an excess-32768 DAC word.
module audio_sample_interp #(
    parameter int FIFO_AW    = 2,
    parameter int PHASE_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    audio_sample_interp_if.slave  s_if,
    input  logic                  clr_underrun_i,
    output logic [15:0]           dac_out_o,
    output logic                  underrun_o,
    output logic [FIFO_AW:0]      fifo_level_o
);
    localparam int                DEPTH = 1 << FIFO_AW;
    localparam int                PW    = 18 + PHASE_BITS;
    localparam logic [FIFO_AW:0]  FULL  = (FIFO_AW + 1)'(DEPTH);

    logic        [15:0]           mem_q [DEPTH];
    logic        [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        [FIFO_AW:0]      level_q, level_d;
    logic        [PHASE_BITS-1:0] phase_q, phase_d;
    logic signed [15:0]           prev_q, prev_d, cur_q, cur_d;
    logic                         under_q, under_d;
    logic        [15:0]           dac_q, dac_d;
    logic                         advance, push, pop;

    // prev + floor(delta*phase / 2^PHASE_BITS); the result stays between prev and cur.
    function automatic logic signed [15:0] interp_fn(input logic signed [15:0] p,
                                                     input logic signed [15:0] c,
                                                     input logic [PHASE_BITS-1:0] ph);
        logic signed [16:0]   delta;
        logic signed [PW-1:0] d_ext, ph_ext, prod, shifted;
        delta   = {c[15], c} - {p[15], p};
        d_ext   = {{(PW-17){delta[16]}}, delta};
        ph_ext  = {{(PW-PHASE_BITS){1'b0}}, ph};
        prod    = d_ext * ph_ext;
        shifted = prod >>> PHASE_BITS;
        return p + shifted[15:0];
    endfunction

    function automatic logic [15:0] to_excess(input logic signed [15:0] v);
        return {~v[15], v[14:0]};
    endfunction

    assign s_if.s_ready = (level_q != FULL);
    assign advance      = (phase_q == '1);
    assign push         = s_if.s_valid && s_if.s_ready;
    assign pop          = advance && (level_q != '0);

    always_comb begin
        phase_d  = phase_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        prev_d   = prev_q;
        cur_d    = cur_q;
        under_d  = under_q;
        dac_d    = to_excess(interp_fn(prev_q, cur_q, phase_q));

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;

        if (advance) begin
            prev_d = cur_q;
            if (pop) cur_d = mem_q[rd_ptr_q];
        end

        // An empty advance outranks a simultaneous clear.
        if (advance && !pop)      under_d = 1'b1;
        else if (clr_underrun_i)  under_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= s_if.s_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            under_q  <= 1'b0;
            dac_q    <= 16'h8000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
            under_q  <= under_d;
            dac_q    <= dac_d;
        end
    end

    assign dac_out_o    = dac_q;
    assign underrun_o   = under_q;
    assign fifo_level_o = level_q;
endmodule
